// File: rtl/zmaps_rd_pkg.sv
// Shared definitions for the Z80 FPGA-RAM window read path: file codes,
// FSM states and the byte-lane helpers.
package zmaps_rd_pkg;

    localparam logic [2:0] FILE_CRAM = 3'b000;
    localparam logic [2:0] FILE_SFYS = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAT  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Lane split matches the write mapper: a[0]=0 is the low byte.
    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

    // Tag layout is {sfile, word address}; only CRAM and SFILE are cacheable.
    function automatic logic inval_hit(
        input logic [8:0] tag,
        input logic       cram_we,
        input logic       sfile_we,
        input logic [7:0] waddr
    );
        return (tag[7:0] == waddr) && ((cram_we && !tag[8]) || (sfile_we && tag[8]));
    endfunction

endpackage

// File: rtl/zmaps_rd_cache.sv
// One-word read cache for the window read path: tag/word/valid storage,
// lookup compare against post-invalidate state, and fill with write snooping.
module zmaps_rd_cache
    import zmaps_rd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  lk_tag,
    output logic        lk_hit,
    output logic [15:0] word,
    input  logic        fill_en,
    input  logic [8:0]  fill_tag,
    input  logic [15:0] fill_word,
    input  logic        wr_cram_we,
    input  logic        wr_sfile_we,
    input  logic [7:0]  wr_addr
);

    logic        valid_q, valid_d;
    logic [8:0]  tag_q, tag_d;
    logic [15:0] word_q, word_d;
    logic        valid_eff;

    always_comb begin
        valid_eff = valid_q && !inval_hit(tag_q, wr_cram_we, wr_sfile_we, wr_addr);
        lk_hit    = valid_eff && (tag_q == lk_tag);
        valid_d   = valid_eff;
        tag_d     = tag_q;
        word_d    = word_q;
        // A write landing on the word being filled leaves the entry invalid.
        if (fill_en) begin
            tag_d   = fill_tag;
            word_d  = fill_word;
            valid_d = !inval_hit(fill_tag, wr_cram_we, wr_sfile_we, wr_addr);
        end
    end

    assign word = word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: rtl/zmaps_rd.sv
// Z80 read-back path for the CRAM/SFILE window: splits byte reads into
// FPRAM word fetches, arbitrates for the read port and caches one word.
module zmaps_rd
    import zmaps_rd_pkg::*;
#(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memrd_s,
    input  logic [15:0] a,
    input  logic [4:0]  fmaddr,
    output logic        zrd_hit,
    output logic [7:0]  zrd_data,
    output logic        zrd_rdy,
    output logic [7:0]  ram_addr,
    output logic        cram_re,
    output logic        sfile_re,
    input  logic        ram_gnt,
    input  logic [15:0] cram_q,
    input  logic [15:0] sfile_q,
    input  logic        wr_cram_we,
    input  logic        wr_sfile_we,
    input  logic [7:0]  wr_addr
);

    localparam logic [1:0] LAT_INIT = 2'(RAM_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        sel_sf_q, sel_sf_d;
    logic        bsel_q, bsel_d;
    logic [7:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  zrd_data_q, zrd_data_d;
    logic        zrd_rdy_q, zrd_rdy_d;
    logic        cram_re_q, cram_re_d;
    logic        sfile_re_q, sfile_re_d;

    logic        hit, mapped, lk_sfile, lk_hit, fill_en;
    logic [15:0] cache_word, q_word;

    zmaps_rd_cache u_cache (
        .clk         (clk),
        .rst         (rst),
        .lk_tag      ({lk_sfile, a[8:1]}),
        .lk_hit      (lk_hit),
        .word        (cache_word),
        .fill_en     (fill_en),
        .fill_tag    ({sel_sf_q, ram_addr_q}),
        .fill_word   (q_word),
        .wr_cram_we  (wr_cram_we),
        .wr_sfile_we (wr_sfile_we),
        .wr_addr     (wr_addr)
    );

    always_comb begin
        hit      = memrd_s && fmaddr[4] && (a[15:12] == fmaddr[3:0]);
        mapped   = (a[11:9] == FILE_CRAM) || (a[11:9] == FILE_SFYS);
        lk_sfile = (a[11:9] == FILE_SFYS);
        q_word   = sel_sf_q ? sfile_q : cram_q;
        fill_en  = (state_q == LAT) && (cnt_q == '0);

        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_sf_d   = sel_sf_q;
        bsel_d     = bsel_q;
        ram_addr_d = ram_addr_q;
        zrd_data_d = zrd_data_q;
        zrd_rdy_d  = 1'b0;
        cram_re_d  = cram_re_q;
        sfile_re_d = sfile_re_q;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (!mapped) begin
                        zrd_data_d = 8'hFF;
                        zrd_rdy_d  = 1'b1;
                        state_d    = DONE;
                    end else if (lk_hit) begin
                        zrd_data_d = byte_sel(cache_word, a[0]);
                        zrd_rdy_d  = 1'b1;
                        state_d    = DONE;
                    end else begin
                        sel_sf_d   = lk_sfile;
                        ram_addr_d = a[8:1];
                        bsel_d     = a[0];
                        cram_re_d  = !lk_sfile;
                        sfile_re_d = lk_sfile;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (ram_gnt) begin
                    cram_re_d  = 1'b0;
                    sfile_re_d = 1'b0;
                    cnt_d      = LAT_INIT;
                    state_d    = LAT;
                end
            end
            LAT: begin
                if (cnt_q == '0) begin
                    zrd_data_d = byte_sel(q_word, bsel_q);
                    zrd_rdy_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_sf_q   <= 1'b0;
            bsel_q     <= 1'b0;
            ram_addr_q <= '0;
            zrd_data_q <= 8'hFF;
            zrd_rdy_q  <= 1'b0;
            cram_re_q  <= 1'b0;
            sfile_re_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_sf_q   <= sel_sf_d;
            bsel_q     <= bsel_d;
            ram_addr_q <= ram_addr_d;
            zrd_data_q <= zrd_data_d;
            zrd_rdy_q  <= zrd_rdy_d;
            cram_re_q  <= cram_re_d;
            sfile_re_q <= sfile_re_d;
        end
    end

    assign zrd_hit  = hit;
    assign zrd_data = zrd_data_q;
    assign zrd_rdy  = zrd_rdy_q;
    assign ram_addr = ram_addr_q;
    assign cram_re  = cram_re_q;
    assign sfile_re = sfile_re_q;

endmodule

// File: tb/tb_zmaps_rd.sv
// Bench for zmaps_rd: three instances (RAM_LAT 1..3) share stimulus; a
// transaction-timeline model predicts every cycle's outputs.
module tb_zmaps_rd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        memrd_s = 1'b0;
    logic [15:0] a = '0;
    logic [4:0]  fmaddr = 5'h1F;
    logic        wr_cram_we = 1'b0, wr_sfile_we = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        ram_gnt = 1'b0;

    logic        zrd_hit_w  [3];
    logic [7:0]  zrd_data_w [3];
    logic        zrd_rdy_w  [3];
    logic [7:0]  ram_addr_w [3];
    logic        cram_re_w  [3];
    logic        sfile_re_w [3];
    logic [15:0] cram_q_w   [3];
    logic [15:0] sfile_q_w  [3];

    logic [15:0] cram_mem  [256];
    logic [15:0] sfile_mem [256];

    // Bench RAM: known contents loaded during reset, word writes otherwise.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                cram_mem[i]  <= {8'(i) ^ 8'hA5, 8'(i)};
                sfile_mem[i] <= {8'(i), 8'(i) ^ 8'h3C};
            end
        end else begin
            if (wr_cram_we)  cram_mem[wr_addr]  <= wr_data;
            if (wr_sfile_we) sfile_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int unsigned L = g + 1;
        logic [17:0] pipe [L];
        logic [15:0] rd_word;
        assign rd_word = sfile_re_w[g] ? sfile_mem[ram_addr_w[g]] : cram_mem[ram_addr_w[g]];
        always @(posedge clk) begin
            pipe[0] <= {ram_gnt && (cram_re_w[g] || sfile_re_w[g]), sfile_re_w[g], rd_word};
            for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
        end
        assign cram_q_w[g]  = (pipe[L-1][17] && !pipe[L-1][16]) ? pipe[L-1][15:0] : 16'hDEAD;
        assign sfile_q_w[g] = (pipe[L-1][17] &&  pipe[L-1][16]) ? pipe[L-1][15:0] : 16'hDEAD;

        zmaps_rd #(.RAM_LAT(L)) dut (
            .clk         (clk),
            .rst         (rst),
            .memrd_s     (memrd_s),
            .a           (a),
            .fmaddr      (fmaddr),
            .zrd_hit     (zrd_hit_w[g]),
            .zrd_data    (zrd_data_w[g]),
            .zrd_rdy     (zrd_rdy_w[g]),
            .ram_addr    (ram_addr_w[g]),
            .cram_re     (cram_re_w[g]),
            .sfile_re    (sfile_re_w[g]),
            .ram_gnt     (ram_gnt),
            .cram_q      (cram_q_w[g]),
            .sfile_q     (sfile_q_w[g]),
            .wr_cram_we  (wr_cram_we),
            .wr_sfile_we (wr_sfile_we),
            .wr_addr     (wr_addr)
        );
    end

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model: per instance, timeline of the outstanding read plus cache contents.
    int          rdy_cyc [3];
    int          fill_cyc[3];
    bit          req_act [3];
    bit          tx_sf   [3];
    bit          tx_b    [3];
    logic [7:0]  tx_addr [3];
    logic [15:0] snap    [3];
    logic [7:0]  pend    [3];
    logic [7:0]  cur     [3];
    bit          cv      [3];
    bit          csf     [3];
    logic [7:0]  caddr   [3];
    logic [15:0] cword   [3];
    int          obs_rdy [3];
    logic [7:0]  obs_dat [3];

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lat=%0d cyc=%0d got=%h want=%h", nm, k + 1, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        req_act[k]  = 1'b0;
        rdy_cyc[k]  = -10;
        fill_cyc[k] = -10;
        cv[k]       = 1'b0;
        cur[k]      = 8'hFF;
        pend[k]     = 8'hFF;
    endtask

    task automatic step(input bit r, input bit rd, input logic [15:0] ad, input logic [4:0] fm,
                        input bit wc, input bit ws, input logic [7:0] wa, input logic [15:0] wd,
                        input bit gn);
        bit win, fsf;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (cyc == rdy_cyc[k]) cur[k] = pend[k];
            chk("zrd_rdy", k, 16'(zrd_rdy_w[k]), 16'(cyc == rdy_cyc[k]));
            chk("zrd_data", k, 16'(zrd_data_w[k]), 16'(cur[k]));
            chk("cram_re", k, 16'(cram_re_w[k]), 16'(req_act[k] && !tx_sf[k]));
            chk("sfile_re", k, 16'(sfile_re_w[k]), 16'(req_act[k] && tx_sf[k]));
            if (req_act[k]) chk("ram_addr", k, 16'(ram_addr_w[k]), 16'(tx_addr[k]));
            if (zrd_rdy_w[k] === 1'b1) begin
                obs_rdy[k] = cyc;
                obs_dat[k] = zrd_data_w[k];
            end
        end
        rst = r; memrd_s = rd; a = ad; fmaddr = fm;
        wr_cram_we = wc; wr_sfile_we = ws; wr_addr = wa; wr_data = wd; ram_gnt = gn;
        #1;
        win = rd && fm[4] && (ad[15:12] == fm[3:0]);
        for (int k = 0; k < 3; k++) chk("zrd_hit", k, 16'(zrd_hit_w[k]), 16'(win));
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                model_reset(k);
            end else begin
                if (cyc == fill_cyc[k]) begin
                    cv[k] = 1'b1; csf[k] = tx_sf[k]; caddr[k] = tx_addr[k]; cword[k] = snap[k];
                end
                if (cv[k] && caddr[k] == wa && ((wc && !csf[k]) || (ws && csf[k]))) cv[k] = 1'b0;
                if (req_act[k] && gn) begin
                    req_act[k]  = 1'b0;
                    snap[k]     = tx_sf[k] ? sfile_mem[tx_addr[k]] : cram_mem[tx_addr[k]];
                    fill_cyc[k] = cyc + k + 1;
                    rdy_cyc[k]  = cyc + k + 2;
                    pend[k]     = tx_b[k] ? snap[k][15:8] : snap[k][7:0];
                end else if (win && !req_act[k] && cyc > rdy_cyc[k]) begin
                    fsf = (ad[11:9] == 3'b001);
                    if (ad[11:9] > 3'b001) begin
                        rdy_cyc[k] = cyc + 1;
                        pend[k]    = 8'hFF;
                    end else if (cv[k] && csf[k] == fsf && caddr[k] == ad[8:1]) begin
                        rdy_cyc[k] = cyc + 1;
                        pend[k]    = ad[0] ? cword[k][15:8] : cword[k][7:0];
                    end else begin
                        req_act[k] = 1'b1;
                        tx_sf[k]   = fsf;
                        tx_addr[k] = ad[8:1];
                        tx_b[k]    = ad[0];
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit gn);
        repeat (n) step(1'b0, 1'b0, 16'h0000, 5'h1F, 1'b0, 1'b0, 8'h00, 16'h0000, gn);
    endtask

    task automatic rd(input logic [15:0] ad, input bit gn);
        step(1'b0, 1'b1, ad, 5'h1F, 1'b0, 1'b0, 8'h00, 16'h0000, gn);
    endtask

    initial begin
        int t0;
        int prev [3];
        for (int k = 0; k < 3; k++) begin
            model_reset(k);
            obs_rdy[k] = -1;
            obs_dat[k] = 8'h00;
        end

        repeat (3) step(1'b1, 1'b0, 16'h0000, 5'h1F, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("rst_data", k, 16'(zrd_data_w[k]), 16'h00FF);
            chk("rst_addr", k, 16'(ram_addr_w[k]), 16'h0000);
        end

        step(1'b0, 1'b0, 16'h0000, 5'h1F, 1'b1, 1'b0, 8'h12, 16'hBEEF, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 5'h1F, 1'b0, 1'b1, 8'h40, 16'hABCD, 1'b1);
        idle(2, 1'b1);

        t0 = cyc; rd(16'hF024, 1'b1); idle(7, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("miss_lat", k, 16'(obs_rdy[k] - t0), 16'(3 + k));
            chk("miss_data", k, 16'(obs_dat[k]), 16'h00EF);
        end

        t0 = cyc; rd(16'hF025, 1'b1); idle(4, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("hit_lat", k, 16'(obs_rdy[k] - t0), 16'd1);
            chk("hit_data", k, 16'(obs_dat[k]), 16'h00BE);
        end

        t0 = cyc; rd(16'hF026, 1'b0); idle(5, 1'b0); idle(8, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("dma_lat", k, 16'(obs_rdy[k] - t0), 16'(8 + k));
            chk("dma_data", k, 16'(obs_dat[k]), 16'h0013);
        end

        rd(16'hF280, 1'b1); idle(7, 1'b1);
        for (int k = 0; k < 3; k++) chk("sf_data", k, 16'(obs_dat[k]), 16'h00CD);
        step(1'b0, 1'b0, 16'h0000, 5'h1F, 1'b0, 1'b1, 8'h40, 16'h1234, 1'b1);
        idle(1, 1'b1);
        t0 = cyc; rd(16'hF281, 1'b1); idle(7, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("inv_lat", k, 16'(obs_rdy[k] - t0), 16'(3 + k));
            chk("inv_data", k, 16'(obs_dat[k]), 16'h0012);
        end

        t0 = cyc; rd(16'hF800, 1'b1); idle(3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("regs_lat", k, 16'(obs_rdy[k] - t0), 16'd1);
            chk("regs_data", k, 16'(obs_dat[k]), 16'h00FF);
            prev[k] = obs_rdy[k];
        end

        step(1'b0, 1'b1, 16'hF024, 5'h0F, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        for (int k = 0; k < 3; k++) chk("off_hit", k, 16'(zrd_hit_w[k]), 16'h0000);
        idle(5, 1'b1);
        for (int k = 0; k < 3; k++) chk("off_nordy", k, 16'(obs_rdy[k]), 16'(prev[k]));

        t0 = cyc; rd(16'hF024, 1'b1); idle(1, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 5'h1F, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        idle(6, 1'b1);
        for (int k = 0; k < 3; k++) chk("abort_nordy", k, 16'(obs_rdy[k] < t0), 16'd1);
        t0 = cyc; rd(16'hF024, 1'b1); idle(7, 1'b1);
        for (int k = 0; k < 3; k++) chk("abort_miss", k, 16'(obs_rdy[k] - t0), 16'(3 + k));

        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  pg;
            logic [15:0] ad;
            logic [4:0]  fm;
            pg = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            ad = {pg, 3'($urandom_range(0, 3)), 8'h10 + 8'($urandom_range(0, 3)), 1'($urandom)};
            fm = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'h1F;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), ad, fm,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 8'h10 + 8'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 3) != 0));
        end
        idle(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
